// File: rtl/fp_unpack_pkg.sv
// Shared types, constants and the per-class decode for the binary32 operand unpacker.
// Build option FP_UNPACK_DAZ_EN: subnormals decode as signed zero and no normalisation state exists.
package fp_wire;

  localparam int          BIAS      = 127;
  localparam int          EXPO_MAX  = 255;
  localparam logic [23:0] QNAN_MANT = 24'hC00000;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  fmt;
  } fp_unpack_in_type;

  typedef struct packed {
    logic        sig;
    logic [9:0]  expo;
    logic [23:0] mant;
    logic        snan;
    logic        qnan;
    logic        inf;
    logic        zero;
  } fp_unpack_out_type;

`ifdef FP_UNPACK_DAZ_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd2
  } fp_unpack_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } fp_unpack_state_e;
`endif

  // Subnormals leave here with expo=1 and no hidden bit; NORM finishes them.
  function automatic fp_unpack_out_type fp_decode(input fp_unpack_in_type op);
    fp_unpack_out_type r;
    logic [7:0]        e;
    logic [22:0]       m;
    e     = op.data[30:23];
    m     = op.data[22:0];
    r     = '0;
    r.sig = op.data[31];
    if (op.fmt != 2'd0) begin
      r.sig  = 1'b0;
      r.qnan = 1'b1;
      r.expo = 10'(EXPO_MAX);
      r.mant = QNAN_MANT;
    end else if (e == 8'hFF) begin
      r.expo = 10'(EXPO_MAX);
      r.mant = {1'b1, m};
      if (m != 23'd0) begin
        r.qnan = m[22];
        r.snan = ~m[22];
      end else begin
        r.inf = 1'b1;
      end
    end else if (e == 8'h00) begin
      if (m == 23'd0) begin
        r.zero = 1'b1;
      end else begin
`ifdef FP_UNPACK_DAZ_EN
        r.zero = 1'b1;
`else
        r.expo = 10'd1;
        r.mant = {1'b0, m};
`endif
      end
    end else begin
      r.expo = {2'b00, e};
      r.mant = {1'b1, m};
    end
    return r;
  endfunction

  function automatic logic fp_needs_norm(input fp_unpack_in_type op);
`ifdef FP_UNPACK_DAZ_EN
    return (op.fmt == 2'd0) & 1'b0;
`else
    return (op.fmt == 2'd0) && (op.data[30:23] == 8'h00) && (op.data[22:0] != 23'd0);
`endif
  endfunction

endpackage

// File: rtl/fp_unpack_lzc.sv
// Leading-zero count of a STEP-bit slice, MSB first, saturating at STEP when the slice is all zero.
module fp_unpack_lzc #(
  parameter int STEP = 4
) (
  input  logic [STEP-1:0] slice_i,
  output logic [3:0]      count_o
);

  // Scanning upward lets the highest set bit overwrite earlier hits.
  always_comb begin
    count_o = 4'(STEP);
    for (int i = 0; i < STEP; i++) begin
      if (slice_i[i]) begin
        count_o = 4'(STEP - 1 - i);
      end
    end
  end

endmodule

// File: rtl/fp_unpack.sv
// Binary32 operand unpacker: class decode, iterative subnormal normalisation, valid/ready on both sides.
// Build option FP_UNPACK_DAZ_EN removes the NORM state and flushes subnormals to zero.
module fp_unpack
  import fp_wire::*;
#(
  parameter int STEP = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_fmt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sig,
  output logic [9:0]  out_expo,
  output logic [23:0] out_mant,
  output logic        out_snan,
  output logic        out_qnan,
  output logic        out_inf,
  output logic        out_zero
);

  fp_unpack_state_e  state_q;
  fp_unpack_out_type res_q;
  fp_unpack_out_type dec_d;
  fp_unpack_in_type  opIn;
  logic              valid_q;
  logic              accept;
  logic              needsNorm;

  // A held result may be replaced in the same cycle it is consumed.
  assign in_ready = ~reset & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  assign opIn      = '{data: in_data, fmt: in_fmt};
  assign dec_d     = fp_decode(opIn);
  assign needsNorm = fp_needs_norm(opIn);

`ifndef FP_UNPACK_DAZ_EN
  logic [3:0]  shift;
  logic [23:0] mantNorm_d;
  logic [9:0]  expoNorm_d;

  fp_unpack_lzc #(.STEP(STEP)) u_lzc (
    .slice_i (res_q.mant[23 -: STEP]),
    .count_o (shift)
  );

  assign mantNorm_d = res_q.mant << shift;
  assign expoNorm_d = res_q.expo - 10'(shift);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            res_q <= dec_d;
`ifndef FP_UNPACK_DAZ_EN
            if (needsNorm) begin
              state_q <= ST_NORM;
              valid_q <= 1'b0;
            end else
`endif
            begin
              state_q <= ST_DONE;
              valid_q <= 1'b1;
            end
          end else if ((state_q == ST_DONE) && out_ready) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
`ifndef FP_UNPACK_DAZ_EN
        ST_NORM: begin
          res_q.mant <= mantNorm_d;
          res_q.expo <= expoNorm_d;
          if (mantNorm_d[23]) begin
            state_q <= ST_DONE;
            valid_q <= 1'b1;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_sig   = res_q.sig;
  assign out_expo  = res_q.expo;
  assign out_mant  = res_q.mant;
  assign out_snan  = res_q.snan;
  assign out_qnan  = res_q.qnan;
  assign out_inf   = res_q.inf;
  assign out_zero  = res_q.zero;

endmodule

// File: tb/tb_fp_unpack.sv
// Scoreboard bench for fp_unpack: directed corner operands plus randomised traffic against a value-level model.
module tb_fp_unpack;

  localparam int STEP = 4;

  logic        clock     = 1'b0;
  logic        reset     = 1'b1;
  logic        in_valid  = 1'b0;
  logic [31:0] in_data   = '0;
  logic [1:0]  in_fmt    = '0;
  logic        out_ready = 1'b1;
  logic        in_ready;
  logic        out_valid;
  logic        out_sig;
  logic [9:0]  out_expo;
  logic [23:0] out_mant;
  logic        out_snan;
  logic        out_qnan;
  logic        out_inf;
  logic        out_zero;

  fp_unpack #(.STEP(STEP)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_fmt    (in_fmt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sig   (out_sig),
    .out_expo  (out_expo),
    .out_mant  (out_mant),
    .out_snan  (out_snan),
    .out_qnan  (out_qnan),
    .out_inf   (out_inf),
    .out_zero  (out_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [38:0] vec;
    int          lat;
    int          acceptCycle;
  } exp_t;

  exp_t        sbQ[$];
  int          cycle        = 0;
  int          checks       = 0;
  int          passes       = 0;
  int          orMode       = 0;
  int          lastPopCycle = -1;
  logic        headSeen     = 1'b0;
  logic        prevStalled  = 1'b0;
  logic [38:0] heldVec      = '0;
  logic [38:0] outVec;

  assign outVec = {out_sig, out_expo, out_mant, out_snan, out_qnan, out_inf, out_zero};

  always @(posedge clock) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cycle);
  endtask

  // Reference: a subnormal is frac * 2^-149; shift its leading one up to bit 23 and lower the exponent by the same amount.
  function automatic exp_t refModel(input logic [31:0] d, input logic [1:0] f);
    exp_t        e;
    logic        s;
    logic [9:0]  ex;
    logic [23:0] mt;
    logic        sn, qn, inf, zr;
    s = d[31]; ex = '0; mt = '0; sn = 0; qn = 0; inf = 0; zr = 0;
    e.lat = 1;
    e.acceptCycle = 0;
    if (f != 2'd0) begin
      s = 0; qn = 1; ex = 10'd255; mt = 24'hC00000;
    end else if (d[30:23] == 8'hFF) begin
      ex = 10'd255;
      if (d[22:0] == 23'd0) begin
        inf = 1; mt = 24'h800000;
      end else begin
        mt = {1'b1, d[22:0]};
        if (d[22]) qn = 1; else sn = 1;
      end
    end else if (d[30:23] == 8'h00) begin
      if (d[22:0] == 23'd0) begin
        zr = 1;
      end else begin
`ifdef FP_UNPACK_DAZ_EN
        zr = 1;
`else
        int p;
        int sh;
        p = 0;
        for (int i = 0; i < 23; i++) if (d[i]) p = i;
        sh    = 23 - p;
        mt    = 24'(d[22:0]) << sh;
        ex    = 10'(1 - sh);
        e.lat = 1 + (sh + STEP - 1) / STEP;
`endif
      end
    end else begin
      ex = {2'b00, d[30:23]};
      mt = {1'b1, d[22:0]};
    end
    e.vec = {s, ex, mt, sn, qn, inf, zr};
    return e;
  endfunction

  task automatic applyStimulus(input logic [31:0] d, input logic [1:0] f, output int waits);
    exp_t e;
    waits = 0;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = d;
    in_fmt   = f;
    #1;
    while (!in_ready && waits < 200) begin
      @(negedge clock);
      #1;
      waits++;
    end
    if (!in_ready) begin
      checkOutput("acceptTimeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      e = refModel(d, f);
      e.acceptCycle = cycle;
      sbQ.push_back(e);
      @(posedge clock);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 500) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, 64'(sbQ.size()), 64'd0);
  endtask

  function automatic void randOperand(output logic [31:0] d, output logic [1:0] f);
    logic [22:0] frac;
    int          b;
    f    = 2'd0;
    frac = 23'($urandom);
    case ($urandom % 8)
      0, 1, 2: d = {1'($urandom), 8'(1 + $urandom % 254), frac};
      3, 4: begin
        b    = 1 + int'($urandom % 23);
        frac = frac & 23'((1 << b) - 1);
        if (frac == 23'd0) frac = 23'd1;
        d = {1'($urandom), 8'h00, frac};
      end
      5: d = {1'($urandom), 31'd0};
      6: d = {1'($urandom), 8'hFF, (($urandom % 4) == 0) ? 23'd0 : frac};
      default: begin
        d = $urandom;
        f = 2'(1 + $urandom % 3);
      end
    endcase
  endfunction

  always @(negedge clock) begin
    case (orMode)
      0:       out_ready = 1'b1;
      1:       out_ready = (($urandom % 4) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: latency on first sight of a result, data on handshake, and hold behaviour while stalled.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        prevStalled = 1'b0;
        headSeen    = 1'b0;
      end else begin
        if (prevStalled) checkOutput("stallStable", {24'd0, out_valid, outVec}, {24'd0, 1'b1, heldVec});
        if (out_valid) begin
          if (sbQ.size() == 0) begin
            checkOutput("unexpectedOut", 64'd1, 64'd0);
          end else begin
            if (!headSeen) begin
              checkOutput("latency", 64'(cycle - sbQ[0].acceptCycle), 64'(sbQ[0].lat));
              headSeen = 1'b1;
            end
            if (out_ready) begin
              checkOutput("result", 64'(outVec), 64'(sbQ[0].vec));
              void'(sbQ.pop_front());
              headSeen     = 1'b0;
              lastPopCycle = cycle;
            end
          end
          if (!out_ready) begin
            checkOutput("stallReady", 64'(in_ready), 64'd0);
            heldVec     = outVec;
            prevStalled = 1'b1;
          end else begin
            prevStalled = 1'b0;
          end
        end else begin
          prevStalled = 1'b0;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          w, w2, w3;
    logic [31:0] d;
    logic [1:0]  f;

    repeat (3) @(negedge clock);
    #1;
    checkOutput("resetValid", 64'(out_valid), 64'd0);
    checkOutput("resetReady", 64'(in_ready), 64'd0);
    checkOutput("resetData", 64'(outVec), 64'd0);
    @(negedge clock);
    reset = 1'b0;

    applyStimulus(32'h3F800000, 2'd0, w);
    applyStimulus(32'h00000001, 2'd0, w);
    applyStimulus(32'h7F800001, 2'd0, w);
    applyStimulus(32'hFFC00000, 2'd0, w);
    applyStimulus(32'hFF800000, 2'd0, w);
    applyStimulus(32'h12345678, 2'd1, w);

    applyStimulus(32'h3F800000, 2'd0, w);
    applyStimulus(32'h40000000, 2'd0, w2);
    applyStimulus(32'h80000000, 2'd0, w3);
    checkOutput("b2bWait", 64'(w2 + w3), 64'd0);
    waitDrain("drainB2b");

    // Five stalled cycles, then the waiting operand must go in on the release handshake.
    orMode = 2;
    applyStimulus(32'h3F800000, 2'd0, w);
    fork
      applyStimulus(32'h40000000, 2'd0, w);
      begin
        repeat (5) @(posedge clock);
        #2;
        orMode = 0;
      end
    join
    checkOutput("stallWait", 64'(w), 64'd5);
    checkOutput("releaseSameCycle", 64'(sbQ[$].acceptCycle), 64'(lastPopCycle));
    waitDrain("drainStall");

    applyStimulus(32'h00000010, 2'd0, w);
    @(negedge clock);
    reset = 1'b1;
    sbQ.delete();
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("resetMidNorm", 64'(out_valid), 64'd0);
    applyStimulus(32'h3F800000, 2'd0, w);
    waitDrain("drainReset");

    orMode = 1;
    repeat (150) begin
      randOperand(d, f);
      applyStimulus(d, f, w);
      if (($urandom % 4) == 0) @(negedge clock);
    end
    orMode = 0;
    waitDrain("finalDrain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
